nn_stream_host: RTL and testbench

Host-side sequencer that drives the `neural_net_2layer` inference block. It deserializes a signed byte stream into IN_N-element input vectors and issues each vector with a one-cycle valid pulse. It then captures the accelerator's OUT_N result words and serializes them onto a 16-bit valid/ready output stream. It sits between the system stream fabric and the accelerator, on the opposite end of the accelerator's `input_valid`/`output_valid` interface.

---
 rtl/nn_stream_host.sv | 152 +++++++++++++++
 tb/tb_nn_stream_host.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_stream_host.sv
// Host-side sequencer for the neural_net_2layer accelerator: packs a signed byte
// stream into IN_N-element vectors and streams the OUT_N result words back out.
module nn_stream_host #(
  parameter int IN_N    = 4,
  parameter int OUT_N   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [7:0]      s_data,
  output logic                   nn_input_valid,
  output logic [IN_N-1:0][7:0]   nn_input_data,
  input  logic                   nn_output_valid,
  input  logic [OUT_N-1:0][15:0] nn_output_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [15:0]     m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [15:0]            vec_count
);

  localparam int MAX_N = (IN_N > OUT_N) ? IN_N : OUT_N;
  localparam int IDX_W = $clog2(MAX_N + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_IN_LAST  = IDX_W'(IN_N - 1);
  localparam logic [IDX_W-1:0] IDX_OUT_LAST = IDX_W'(OUT_N - 1);
  localparam logic [TMR_W-1:0] TMR_LAST     = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    SEND    = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [TMR_W-1:0]       timer, timer_n;
  logic [IN_N-1:0][7:0]   slot_n;
  logic [OUT_N-1:0][15:0] result, result_n;
  logic [15:0]            vec_count_n;
  logic                   timeout_n;
  logic [15:0]            word_n;

  // Next-state and datapath update; every output register is derived from these.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    timer_n     = timer;
    slot_n      = nn_input_data;
    result_n    = result;
    vec_count_n = vec_count;
    timeout_n   = 1'b0;
    case (state)
      COLLECT: begin
        if (s_valid && s_ready) begin
          for (int i = 0; i < IN_N; i++) begin
            slot_n[i] = (idx == IDX_W'(i)) ? s_data : nn_input_data[i];
          end
          idx_n = idx + IDX_W'(1);
          if (idx == IDX_IN_LAST) begin
            state_n = ISSUE;
          end else begin
            state_n = COLLECT;
          end
        end else begin
          state_n = COLLECT;
        end
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        timer_n = timer + TMR_W'(1);
        // A result arriving on the final allowed cycle still beats the timeout.
        if (nn_output_valid) begin
          result_n = nn_output_data;
          idx_n    = '0;
          state_n  = SEND;
        end else if (timer == TMR_LAST) begin
          idx_n     = '0;
          timeout_n = 1'b1;
          state_n   = COLLECT;
        end else begin
          state_n = WAIT;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (idx == IDX_OUT_LAST) begin
            vec_count_n = vec_count + 16'd1;
            idx_n       = '0;
            state_n     = COLLECT;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = SEND;
          end
        end else begin
          state_n = SEND;
        end
      end
      default: begin
        idx_n   = '0;
        state_n = COLLECT;
      end
    endcase

    word_n = '0;
    for (int i = 0; i < OUT_N; i++) begin
      word_n = (idx_n == IDX_W'(i)) ? result_n[i] : word_n;
    end
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= COLLECT;
      idx            <= '0;
      timer          <= '0;
      nn_input_data  <= '0;
      result         <= '0;
      vec_count      <= 16'd0;
      s_ready        <= 1'b0;
      nn_input_valid <= 1'b0;
      m_valid        <= 1'b0;
      m_data         <= 16'sd0;
      m_last         <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      timer          <= timer_n;
      nn_input_data  <= slot_n;
      result         <= result_n;
      vec_count      <= vec_count_n;
      s_ready        <= (state_n == COLLECT);
      nn_input_valid <= (state_n == ISSUE);
      m_valid        <= (state_n == SEND);
      m_data         <= (state_n == SEND) ? word_n : m_data;
      m_last         <= (state_n == SEND) && (idx_n == IDX_OUT_LAST);
      busy           <= (state_n != COLLECT) || (idx_n != '0);
      timeout_err    <= timeout_n;
    end
  end

endmodule

// File: tb/tb_nn_stream_host.sv
// Scoreboard bench for nn_stream_host with a behavioural accelerator stand-in
// (weights chosen so that bytes 1,2,3,4 yield 22,31 and all -1 yields 0,0).
module tb_nn_stream_host;

  typedef logic [3:0][7:0]  vec_t;
  typedef logic [1:0][15:0] res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        nn_input_valid;
  vec_t        nn_input_data;
  logic        nn_output_valid;
  res_t        nn_output_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        timeout_err;
  logic [15:0] vec_count;

  int          n_chk = 0;
  int          n_fail = 0;
  int          mr_mode = 2;
  int          seen_timeouts = 0;
  int          exp_timeouts = 0;
  logic [15:0] exp_vec_count = 16'd0;
  vec_t        vec_q[$];
  int          delay_q[$];
  logic [16:0] word_q[$];

  nn_stream_host #(.IN_N(4), .OUT_N(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .nn_input_valid(nn_input_valid), .nn_input_data(nn_input_data),
    .nn_output_valid(nn_output_valid), .nn_output_data(nn_output_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .timeout_err(timeout_err), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  // Two-layer ReLU network: h0=relu(sum x), h1=relu(x0); y0=2h0+2h1, y1=3h0+h1.
  function automatic res_t nn_ref(input vec_t v);
    int h0;
    int h1;
    res_t r;
    h0 = 0;
    for (int i = 0; i < 4; i++) h0 += int'($signed(v[i]));
    h1 = int'($signed(v[0]));
    if (h0 < 0) h0 = 0;
    if (h1 < 0) h1 = 0;
    r[0] = 16'(2 * h0 + 2 * h1);
    r[1] = 16'(3 * h0 + h1);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit gaps);
    bit done;
    done = 1'b0;
    if (gaps) tick($urandom_range(0, 2));
    s_valid = 1'b1;
    s_data  = b;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
    end
    if (!done) bound_fail("byte_accept");
    s_valid = 1'b0;
  endtask

  // delay: WAIT cycle in which the accelerator answers; 0 or >15 means a timeout.
  task automatic push_vec(input vec_t v, input int delay, input bit gaps);
    res_t r;
    vec_q.push_back(v);
    delay_q.push_back(delay);
    if (delay >= 1 && delay <= 15) begin
      r = nn_ref(v);
      word_q.push_back({1'b0, r[0]});
      word_q.push_back({1'b1, r[1]});
    end else begin
      exp_timeouts++;
    end
    for (int i = 0; i < 4; i++) drive_byte(v[i], gaps);
  endtask

  task automatic raw_bytes(input int n);
    for (int i = 0; i < n; i++) drive_byte(8'($urandom), 1'b0);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      tick(1);
      done = (word_q.size() == 0) && (vec_q.size() == 0) && !busy && !timeout_err;
    end
    if (!done) bound_fail("idle_wait");
    tick(1);
    chk("vec_count", 64'(vec_count), 64'(exp_vec_count));
    chk("timeouts", 64'(seen_timeouts), 64'(exp_timeouts));
  endtask

  task automatic flush();
    vec_q.delete();
    delay_q.delete();
    word_q.delete();
    exp_vec_count = 16'd0;
  endtask

  // Accelerator stand-in: answers a chosen number of cycles after the issue pulse.
  initial begin
    int   pend;
    res_t res;
    pend = 0;
    res = '0;
    nn_output_valid = 1'b0;
    nn_output_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      nn_output_valid = 1'b0;
      nn_output_data  = 32'($urandom);
      if (rst) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          nn_output_valid = 1'b1;
          nn_output_data  = res;
        end
      end
      if (nn_input_valid && !rst) begin
        pend = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
        res  = nn_ref(nn_input_data);
      end
    end
  end

  // Sink ready: 0 = always ready, 1 = random, 2 = driven by the main sequence.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mr_mode == 0) m_ready = 1'b1;
      else if (mr_mode == 1) m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stream invariants.
  initial begin
    bit          prev_iv;
    bit          hold_pend;
    logic [15:0] held_d;
    logic        held_l;
    vec_t        ev;
    logic [16:0] ew;
    prev_iv = 1'b0;
    hold_pend = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_iv   = 1'b0;
        hold_pend = 1'b0;
      end else begin
        chk("ready_valid_excl", 64'(s_ready & m_valid), 64'd0);
        if (nn_input_valid) begin
          chk("issue_single_cycle", 64'(prev_iv), 64'd0);
          if (vec_q.size() == 0) bound_fail("unexpected_issue");
          else begin
            ev = vec_q.pop_front();
            chk("issue_vector", 64'(nn_input_data), 64'(ev));
          end
        end
        prev_iv = nn_input_valid;
        if (hold_pend && m_valid) begin
          chk("hold_data", 64'(m_data), 64'(held_d));
          chk("hold_last", 64'(m_last), 64'(held_l));
        end
        hold_pend = m_valid && !m_ready;
        held_d = m_data;
        held_l = m_last;
        if (m_valid && m_ready) begin
          if (word_q.size() == 0) bound_fail("unexpected_word");
          else begin
            ew = word_q.pop_front();
            chk("m_data", 64'(m_data), 64'(ew[15:0]));
            chk("m_last", 64'(m_last), 64'(ew[16]));
            if (ew[16]) exp_vec_count = exp_vec_count + 16'd1;
          end
        end
        if (timeout_err) seen_timeouts++;
      end
    end
  end

  initial begin
    vec_t v;
    vec_t v1234;
    int   r;
    v1234 = {8'd4, 8'd3, 8'd2, 8'd1};
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'd0;
    m_ready = 1'b0;
    tick(3);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_iv", 64'(nn_input_valid), 64'd0);
    chk("rst_data", 64'(nn_input_data), 64'd0);
    chk("rst_outs", 64'({m_data, m_last, busy, timeout_err, vec_count}), 64'd0);
    rst = 1'b0;
    tick(2);
    chk("s_ready_after_rst", 64'(s_ready), 64'd1);

    // Directed vector with latency checks.
    mr_mode = 0;
    m_ready = 1'b1;
    push_vec(v1234, 1, 1'b0);
    chk("dir_issue", 64'(nn_input_valid), 64'd1);
    tick(1);
    chk("dir_wait_busy", 64'({busy, m_valid, nn_input_valid}), 64'b100);
    tick(1);
    chk("dir_w0", 64'({m_valid, m_data, m_last}), 64'({1'b1, 16'd22, 1'b0}));
    tick(1);
    chk("dir_w1", 64'({m_valid, m_data, m_last}), 64'({1'b1, 16'd31, 1'b1}));
    tick(1);
    chk("dir_done", 64'({vec_count, s_ready, busy}), 64'({16'd1, 1'b1, 1'b0}));
    wait_idle();

    // Backpressure: hold ready low for five cycles.
    mr_mode = 2;
    m_ready = 1'b0;
    push_vec(v1234, 1, 1'b0);
    tick(2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", 64'({m_valid, m_data, s_ready}), 64'({1'b1, 16'd22, 1'b0}));
      tick(1);
    end
    m_ready = 1'b1;
    mr_mode = 0;
    tick(1);
    chk("bp_w1", 64'({m_data, m_last}), 64'({16'd31, 1'b1}));
    wait_idle();

    // Timeout, then a normal vector.
    push_vec(v1234, 0, 1'b0);
    tick(15);
    chk("to_not_yet", 64'(timeout_err), 64'd0);
    tick(1);
    chk("to_pulse", 64'({timeout_err, s_ready, m_valid}), 64'b110);
    tick(1);
    chk("to_one_cycle", 64'(timeout_err), 64'd0);
    push_vec(v1234, 1, 1'b0);
    wait_idle();

    // Result arrives on the 15th WAIT cycle.
    push_vec(v1234, 15, 1'b0);
    tick(16);
    chk("race", 64'({m_valid, timeout_err}), 64'b10);
    wait_idle();

    // Reset after two bytes.
    raw_bytes(2);
    chk("partial_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    flush();
    tick(1);
    chk("rst_mid_data", 64'(nn_input_data), 64'd0);
    chk("rst_mid_outs", 64'({s_ready, busy, m_valid, nn_input_valid, vec_count}), 64'd0);
    rst = 1'b0;
    tick(1);
    push_vec({8'd9, 8'd8, 8'd7, 8'd6}, 1, 1'b0);
    wait_idle();

    // Reset during SEND.
    mr_mode = 2;
    m_ready = 1'b0;
    push_vec(v1234, 1, 1'b0);
    tick(2);
    chk("send_before_rst", 64'(m_valid), 64'd1);
    rst = 1'b1;
    flush();
    tick(1);
    chk("send_rst", 64'({m_valid, m_last}), 64'd0);
    rst = 1'b0;
    mr_mode = 0;
    m_ready = 1'b1;
    tick(1);

    // All -1 bytes clamp to zero.
    push_vec({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1, 1'b0);
    tick(2);
    chk("neg_w0", 64'({m_valid, m_data}), 64'({1'b1, 16'd0}));
    wait_idle();

    // Counter wrap.
    force dut.vec_count = 16'hFFFF;
    tick(1);
    release dut.vec_count;
    exp_vec_count = 16'hFFFF;
    push_vec(v1234, 1, 1'b0);
    wait_idle();
    chk("wrap_zero", 64'(vec_count), 64'd0);

    // Randomized traffic.
    mr_mode = 1;
    for (int n = 0; n < 30; n++) begin
      v = 32'($urandom);
      r = $urandom_range(0, 9);
      push_vec(v, (r < 6) ? 1 : (r < 8) ? $urandom_range(2, 15) :
                  (r == 8) ? 0 : $urandom_range(16, 18), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    chk("queue_drained", 64'(word_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation budget expired");
    $fatal(1);
  end

endmodule
